// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue/writeback controller for the 8-bit combinational ALU
// Three-cycle IDLE/EXEC/DONE sequencer with an 8x8 register file and retire counter.
module alu_issue #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int AW     = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [AW-1:0]     instr_rd,
    input  logic [AW-1:0]     instr_rs,
    input  logic [AW-1:0]     instr_rt,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              carry_flag,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD      = 4'b0000;
    localparam logic [3:0] OP_SUB      = 4'b0001;
    localparam logic [3:0] OP_LAST_ALU = 4'b1100;
    localparam logic [3:0] OP_LDI      = 4'b1101;

    state_t state_q, state_d;

    logic [3:0]        op_q, op_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] opx_q, opx_d;
    logic [DATA_W-1:0] opy_q, opy_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_carry_q, res_carry_d;
    logic              carry_flag_q, carry_flag_d;
    logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;

    logic is_arith;
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        alu_ctrl    = OP_LDI;
        alu_x       = '0;
        alu_y       = '0;
        case (state_q)
            ST_IDLE: instr_ready = 1'b1;
            ST_EXEC: begin
                alu_ctrl = op_q;
                alu_x    = opx_q;
                alu_y    = opy_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        op_d          = op_q;
        rd_d          = rd_q;
        imm_d         = imm_q;
        opx_d         = opx_q;
        opy_d         = opy_q;
        regs_d        = regs_q;
        res_valid_d   = (state_q == ST_EXEC);
        res_data_d    = res_data_q;
        res_carry_d   = res_carry_q;
        carry_flag_d  = carry_flag_q;
        retired_cnt_d = retired_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Operands are snapshotted here; rd==rs/rt is safe because writeback lands later.
                if (instr_valid) begin
                    op_d  = instr_op;
                    rd_d  = instr_rd;
                    imm_d = instr_imm;
                    opx_d = regs_q[instr_rs];
                    opy_d = regs_q[instr_rt];
                end
            end
            ST_EXEC: begin
                if (op_q == OP_LDI) begin
                    regs_d[rd_q] = imm_q;
                    res_data_d   = imm_q;
                end else if (op_q <= OP_LAST_ALU) begin
                    regs_d[rd_q] = alu_out;
                    res_data_d   = alu_out;
                end else begin
                    res_data_d = '0;
                end
                if (is_arith) begin
                    res_carry_d  = alu_carry;
                    carry_flag_d = alu_carry;
                end else begin
                    res_carry_d = 1'b0;
                end
            end
            ST_DONE: retired_cnt_d = retired_cnt_q + CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            opx_q         <= '0;
            opy_q         <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_carry_q   <= 1'b0;
            carry_flag_q  <= 1'b0;
            retired_cnt_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            op_q          <= op_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            opx_q         <= opx_d;
            opy_q         <= opy_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_carry_q   <= res_carry_d;
            carry_flag_q  <= carry_flag_d;
            retired_cnt_q <= retired_cnt_d;
            regs_q        <= regs_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_carry   = res_carry_q;
    assign carry_flag  = carry_flag_q;
    assign retired_cnt = retired_cnt_q;
    assign rd_data     = regs_q[rd_addr];

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue
// Includes a behavioural model of the external combinational ALU.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_op = '0;
    logic [2:0]  instr_rd = '0;
    logic [2:0]  instr_rs = '0;
    logic [2:0]  instr_rt = '0;
    logic [7:0]  instr_imm = '0;
    logic [3:0]  alu_ctrl;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_carry;
    logic        carry_flag;
    logic [2:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic [15:0] retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    logic       g_valid, g_carry, g_lat_valid, g_ex_ready;
    logic [7:0] g_data, g_ex_x, g_ex_y, g_ex_rd;
    logic [3:0] g_ex_ctrl;
    logic [7:0] v;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs    (instr_rs),
        .instr_rt    (instr_rt),
        .instr_imm   (instr_imm),
        .alu_ctrl    (alu_ctrl),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_carry   (res_carry),
        .carry_flag  (carry_flag),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .retired_cnt (retired_cnt)
    );

    // ALU model: unlisted opcodes return a loud pattern with carry set.
    logic [8:0]  sum9;
    logic [15:0] shl;
    always_comb begin
        alu_out   = 8'hA5;
        alu_carry = 1'b1;
        sum9      = {1'b0, alu_x} + {1'b0, alu_y};
        shl       = {8'h00, alu_y} << alu_x[2:0];
        case (alu_ctrl)
            4'b0000: begin alu_out = sum9[7:0];   alu_carry = sum9[8];        end
            4'b0001: begin alu_out = alu_x - alu_y; alu_carry = alu_x < alu_y; end
            4'b0010: begin alu_out = alu_x & alu_y; alu_carry = 1'b0;         end
            4'b0011: begin alu_out = alu_x | alu_y; alu_carry = 1'b0;         end
            4'b0100: begin alu_out = alu_x ^ alu_y; alu_carry = 1'b0;         end
            4'b0111: begin alu_out = shl[7:0];    alu_carry = |shl[15:8];     end
            4'b1100: begin alu_out = {7'b0, alu_x == alu_y}; alu_carry = 1'b0; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] val);
        rd_addr = a;
        #1;
        val = rd_data;
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [7:0] imm);
        instr_op  = op;
        instr_rd  = rd;
        instr_rs  = rs;
        instr_rt  = rt;
        instr_imm = imm;
    endtask

    // Issues one instruction and returns at the IDLE negedge after retirement.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [7:0] imm);
        int n = 0;
        @(negedge clk);
        drive(op, rd, rs, rt, imm);
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        g_lat_valid = res_valid;
        g_ex_ready  = instr_ready;
        g_ex_ctrl   = alu_ctrl;
        g_ex_x      = alu_x;
        g_ex_y      = alu_y;
        g_ex_rd     = rd_data;
        @(negedge clk);
        g_valid = res_valid;
        g_data  = res_data;
        g_carry = res_carry;
        @(negedge clk);
        exp_cnt++;
        check("exec_res_valid_low", {31'b0, g_lat_valid}, 32'd0);
        check("exec_ready_low", {31'b0, g_ex_ready}, 32'd0);
        check("done_res_valid", {31'b0, g_valid}, 32'd1);
        check("retired_cnt", {16'b0, retired_cnt}, exp_cnt);
    endtask

    logic [3:0] b_op  [3] = '{4'b1101, 4'b1101, 4'b0000};
    logic [2:0] b_rd  [3] = '{3'd1, 3'd2, 3'd3};
    logic [7:0] b_imm [3] = '{8'h11, 8'h22, 8'h00};
    logic [7:0] b_exp [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int pulses;
        logic acc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, instr_ready}, 32'd1);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'hD);
        check("rst_alu_x", {24'b0, alu_x}, 32'd0);
        check("rst_retired", {16'b0, retired_cnt}, 32'd0);
        check("rst_carry_flag", {31'b0, carry_flag}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, instr_ready}, 32'd1);

        // LDI / ADD without carry; rd_addr=3 shows old value during EXEC
        issue(4'b1101, 3'd1, 3'd0, 3'd0, 8'h7F);
        check("ldi_res_data", {24'b0, g_data}, 32'h7F);
        check("ldi_res_carry", {31'b0, g_carry}, 32'd0);
        issue(4'b1101, 3'd2, 3'd0, 3'd0, 8'h01);
        rd_addr = 3'd3;
        issue(4'b0000, 3'd3, 3'd1, 3'd2, 8'h00);
        check("add_exec_ctrl", {28'b0, g_ex_ctrl}, 32'h0);
        check("add_exec_x", {24'b0, g_ex_x}, 32'h7F);
        check("add_exec_y", {24'b0, g_ex_y}, 32'h01);
        check("add_exec_rd_old", {24'b0, g_ex_rd}, 32'h00);
        check("add_res_data", {24'b0, g_data}, 32'h80);
        check("add_res_carry", {31'b0, g_carry}, 32'd0);
        peek(3'd3, v);
        check("add_r3", {24'b0, v}, 32'h80);
        check("idle_alu_ctrl", {28'b0, alu_ctrl}, 32'hD);

        // ADD with carry out, then AND holds the flag
        issue(4'b1101, 3'd4, 3'd0, 3'd0, 8'hFF);
        issue(4'b1101, 3'd5, 3'd0, 3'd0, 8'h01);
        issue(4'b0000, 3'd6, 3'd4, 3'd5, 8'h00);
        check("addc_res_data", {24'b0, g_data}, 32'h00);
        check("addc_res_carry", {31'b0, g_carry}, 32'd1);
        check("addc_carry_flag", {31'b0, carry_flag}, 32'd1);
        issue(4'b0010, 3'd7, 3'd4, 3'd5, 8'h00);
        check("and_res_data", {24'b0, g_data}, 32'h01);
        check("and_carry_flag", {31'b0, carry_flag}, 32'd1);

        // SUB borrow sets/clears the flag; shift carry must not reach res_carry
        issue(4'b1101, 3'd1, 3'd0, 3'd0, 8'h03);
        issue(4'b1101, 3'd2, 3'd0, 3'd0, 8'h81);
        issue(4'b0001, 3'd5, 3'd1, 3'd2, 8'h00);
        check("sub_res_data", {24'b0, g_data}, 32'h82);
        check("sub_carry_flag", {31'b0, carry_flag}, 32'd1);
        issue(4'b0001, 3'd6, 3'd1, 3'd1, 8'h00);
        check("sub0_carry_flag", {31'b0, carry_flag}, 32'd0);
        issue(4'b0111, 3'd3, 3'd1, 3'd2, 8'h00);
        check("shl_res_data", {24'b0, g_data}, 32'h08);
        check("shl_res_carry", {31'b0, g_carry}, 32'd0);
        check("shl_carry_flag", {31'b0, carry_flag}, 32'd0);
        peek(3'd3, v);
        check("shl_r3", {24'b0, v}, 32'h08);
        issue(4'b1100, 3'd4, 3'd3, 3'd3, 8'h00);
        peek(3'd4, v);
        check("op12_r4", {24'b0, v}, 32'h01);

        // Back-to-back with instr_valid held high
        @(negedge clk);
        k = 0;
        pulses = 0;
        drive(b_op[0], b_rd[0], 3'd1, 3'd2, b_imm[0]);
        instr_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            check("b2b_ready", {31'b0, instr_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
            check("b2b_res_valid", {31'b0, res_valid}, (c % 3 == 2) ? 32'd1 : 32'd0);
            if (res_valid) begin
                pulses++;
                check("b2b_res_data", {24'b0, res_data}, {24'b0, b_exp[c / 3]});
            end
            acc = instr_ready && instr_valid;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                k++;
                if (k < 3) drive(b_op[k], b_rd[k], 3'd1, 3'd2, b_imm[k]);
                else instr_valid = 1'b0;
            end
        end
        exp_cnt += 3;
        check("b2b_pulses", pulses, 32'd3);
        check("b2b_retired", {16'b0, retired_cnt}, exp_cnt);
        peek(3'd3, v);
        check("b2b_r3", {24'b0, v}, 32'h33);

        // Reset during EXEC aborts the instruction
        @(negedge clk);
        drive(4'b0000, 3'd3, 3'd1, 3'd2, 8'h00);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        check("abort_in_exec", {31'b0, instr_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_res_valid", {31'b0, res_valid}, 32'd0);
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        check("abort_ready", {31'b0, instr_ready}, 32'd1);
        check("abort_res_valid2", {31'b0, res_valid}, 32'd0);
        check("abort_retired", {16'b0, retired_cnt}, 32'd0);
        peek(3'd3, v);
        check("abort_r3", {24'b0, v}, 32'h00);

        // NOP writes nothing but still retires
        issue(4'b1101, 3'd2, 3'd0, 3'd0, 8'h55);
        issue(4'b1110, 3'd2, 3'd2, 3'd2, 8'h00);
        check("nop_res_data", {24'b0, g_data}, 32'h00);
        check("nop_res_carry", {31'b0, g_carry}, 32'd0);
        peek(3'd2, v);
        check("nop_r2", {24'b0, v}, 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue/writeback controller that sits on the initiator side of the 8-bit combinational ALU (ctrl/x/y in, out/carry back).
- Accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal 8x8 register file.
- Drives the ALU for one cycle, captures out/carry, and writes the result back to the register file.
- Also provides load-immediate, a debug read port, a carry flag and a retired-instruction counter.

Parameters:
- DATA_W, 8: datapath width; only 8 is supported (ALU width).
- NREG, 8: register-file depth.
- AW, 3: register address width, log2(NREG).
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  block can accept; 1 only in IDLE.
- instr_op  in  4  opcode, same encoding as the ALU ctrl.
- instr_rd  in  AW  destination register.
- instr_rs  in  AW  source register, driven onto alu_x.
- instr_rt  in  AW  source register, driven onto alu_y.
- instr_imm  in  DATA_W  immediate, used only by LDI (op 1101).
- alu_ctrl  out  4  to ALU ctrl.
- alu_x  out  DATA_W  to ALU x.
- alu_y  out  DATA_W  to ALU y.
- alu_out  in  DATA_W  from ALU out (combinational return).
- alu_carry  in  1  from ALU carry.
- res_valid  out  1  one-cycle pulse when an instruction retires.
- res_data  out  DATA_W  retired result.
- res_carry  out  1  carry of the retired instruction.
- carry_flag  out  1  sticky carry from the last ADD/SUB.
- rd_addr  in  AW  debug read address.
- rd_data  out  DATA_W  combinational R[rd_addr].
- retired_cnt  out  CNT_W  count of retired instructions; wraps.

Behaviour:
- Clock and reset
  - One clock domain.
  - rst_n low asynchronously clears: all R[i], carry_flag, res_valid, res_data, res_carry, retired_cnt and the operand registers to 0; FSM goes to IDLE; alu_ctrl = 4'b1101.
  - instr_ready is 1 in the first cycle after release.
- FSM states: IDLE -> EXEC -> DONE -> IDLE. Each state lasts exactly one cycle, except IDLE, which waits for instr_valid.
- IDLE
  - instr_ready = 1.
  - On an edge with instr_valid=1: latch op, rd and imm; latch R[rs] into opx and R[rt] into opy; go to EXEC.
  - Operands are sampled at the accept edge; a writeback always completes before the next accept, so there is no hazard.
- EXEC
  - instr_ready = 0; alu_ctrl = op, alu_x = opx, alu_y = opy, all from registers.
  - On the edge leaving EXEC, by op:
    - 0000 to 1100: R[rd] <= alu_out; res_data <= alu_out.
    - 1101 (LDI): R[rd] <= imm; res_data <= imm; ALU result ignored.
    - 1110, 1111 (NOP): no register write; res_data <= 0.
  - res_carry <= alu_carry for ops 0000/0001, else 0.
  - carry_flag <= alu_carry for ops 0000/0001 only, otherwise it holds.
  - res_valid <= 1.
- DONE
  - res_valid = 1 for exactly this cycle; instr_ready = 0.
  - On the next edge: res_valid <= 0, retired_cnt <= retired_cnt + 1 (mod 2^CNT_W), go to IDLE.
- Outside EXEC: alu_ctrl = 4'b1101 and alu_x = alu_y = 0, so the ALU output is quiet.
- Timing
  - Latency from accept edge to res_valid high: 1 cycle.
  - Throughput: 1 instruction per 3 cycles.
- Handshake
  - instr_valid while instr_ready=0 is ignored and not queued; the sender must hold it until it is accepted.
  - Instruction fields matter only on the accept edge.
- Simultaneous events and corner cases
  - rd equal to rs or rt is legal: sources were read at accept, and the new value is written at the end of EXEC.
  - rd_addr equal to the register being written shows the old value until the write edge, then the new value.
- Reset mid-operation (EXEC or DONE): the instruction is aborted, with no writeback and no counter increment.

Test Plan:
- Reset, then LDI R1=0x7F and LDI R2=0x01; ADD rd=3 rs=1 rt=2 -> res_data=0x80, res_carry=0, R3=0x80, retired_cnt=3.
- LDI R4=0xFF, LDI R5=0x01; ADD rd=6 rs=4 rt=5 -> res_data=0x00, res_carry=1, carry_flag=1. Then AND rd=7 rs=4 rt=5 -> res_data=0x01, carry_flag stays 1.
- LDI R1=3, LDI R2=0x81; op 0111 rd=3 rs=1 rt=2 -> R3=0x08. Then op 1100 rd=4 rs=3 rt=3 -> R4=0x01.
- Hold instr_valid=1 continuously with 3 queued instructions -> instr_ready pattern 1,0,0 repeating; exactly 3 res_valid pulses 3 cycles apart; no instruction duplicated or dropped.
- Issue ADD, assert rst_n=0 during EXEC -> no register write, res_valid stays 0, retired_cnt=0, instr_ready=1 after release.
- Op 1110 rd=2 after LDI R2=0x55 -> res_valid pulses, res_data=0x00, R2 still 0x55, retired_cnt increments.
